// File: rtl/memory_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memory_controller                                                    |
// | Owns the 8-bit RAM/IO port: sequences LSB loads/stores and IF word   |
// | fetches as little-endian byte transfers.                             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module memory_controller #(
  parameter int XLEN  = 32,
  parameter int ROB_W = 3,
  parameter int OP_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             lsb_mem_enable,
  input  logic [OP_W-1:0]  lsb_mem_op,
  input  logic [XLEN-1:0]  lsb_mem_addr,
  input  logic [XLEN-1:0]  lsb_mem_data,
  input  logic [ROB_W-1:0] lsb_mem_id,
  input  logic             if_req,
  input  logic [XLEN-1:0]  if_addr,
  input  logic [7:0]       ram_din,
  output logic [7:0]       ram_dout,
  output logic [XLEN-1:0]  ram_a,
  output logic             ram_wr,
  output logic             mem_busy,
  output logic             mem_data_ready,
  output logic [XLEN-1:0]  mem_data,
  output logic [ROB_W-1:0] mem_id,
  output logic             store_done,
  output logic             if_data_ready,
  output logic [XLEN-1:0]  if_data
);

  localparam logic [OP_W-1:0] OP_LB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LH  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_LW  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_LBU = OP_W'(4);
  localparam logic [OP_W-1:0] OP_LHU = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SB  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SH  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SW  = OP_W'(8);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    FETCH = 2'd3
  } state_t;

  state_t           r_state;
  logic [2:0]       r_cnt;
  logic [OP_W-1:0]  r_op;
  logic [XLEN-1:0]  r_base;
  logic [XLEN-1:0]  r_data;
  logic [XLEN-1:0]  r_buf;
  logic [ROB_W-1:0] r_id;
  logic             r_wr;
  logic             r_rdy_d;
  logic [7:0]       r_hold;

  logic [2:0]       w_len;
  logic [2:0]       w_next_idx;
  logic [XLEN-1:0]  w_next_addr;
  logic [1:0]       w_byte_sel;
  logic [7:0]       w_din;
  logic [XLEN-1:0]  w_word;
  logic [XLEN-1:0]  w_ext;
  logic             w_is_store;

  assign mem_busy = (r_state != IDLE) | lsb_mem_enable;
  assign ram_wr   = r_wr & rdy;

  assign w_is_store  = (lsb_mem_op == OP_SB) || (lsb_mem_op == OP_SH) || (lsb_mem_op == OP_SW);
  assign w_next_idx  = r_cnt + 3'd1;
  assign w_next_addr = r_base + {{(XLEN-3){1'b0}}, w_next_idx};
  assign w_byte_sel  = r_cnt[1:0] - 2'd1;
  // RAM keeps answering the held address while stalled, so the byte that
  // belongs to the last active cycle is parked in r_hold.
  assign w_din       = r_rdy_d ? ram_din : r_hold;

  always_comb begin
    w_len = 3'd4;
    if (r_state != FETCH) begin
      case (r_op)
        OP_LB, OP_LBU, OP_SB: w_len = 3'd1;
        OP_LH, OP_LHU, OP_SH: w_len = 3'd2;
        default:              w_len = 3'd4;
      endcase
    end
  end

  always_comb begin
    w_word = r_buf;
    w_word[{w_byte_sel, 3'b000} +: 8] = w_din;
  end

  always_comb begin
    case (r_op)
      OP_LB:   w_ext = {{(XLEN-8){w_word[7]}}, w_word[7:0]};
      OP_LH:   w_ext = {{(XLEN-16){w_word[15]}}, w_word[15:0]};
      OP_LBU:  w_ext = {{(XLEN-8){1'b0}}, w_word[7:0]};
      OP_LHU:  w_ext = {{(XLEN-16){1'b0}}, w_word[15:0]};
      OP_LW:   w_ext = w_word;
      default: w_ext = w_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_cnt          <= 3'd0;
      r_op           <= '0;
      r_base         <= '0;
      r_data         <= '0;
      r_buf          <= '0;
      r_id           <= '0;
      r_wr           <= 1'b0;
      r_rdy_d        <= 1'b0;
      r_hold         <= 8'd0;
      ram_a          <= '0;
      ram_dout       <= 8'd0;
      mem_data_ready <= 1'b0;
      mem_data       <= '0;
      mem_id         <= '0;
      store_done     <= 1'b0;
      if_data_ready  <= 1'b0;
      if_data        <= '0;
    end else begin
      r_rdy_d <= rdy;
      if (r_rdy_d) r_hold <= ram_din;
      if (rdy) begin
        mem_data_ready <= 1'b0;
        store_done     <= 1'b0;
        if_data_ready  <= 1'b0;
        case (r_state)
          IDLE: begin
            if (lsb_mem_enable && !flush) begin
              r_op   <= lsb_mem_op;
              r_base <= lsb_mem_addr;
              r_data <= lsb_mem_data;
              r_id   <= lsb_mem_id;
              r_cnt  <= 3'd0;
              r_buf  <= '0;
              ram_a  <= lsb_mem_addr;
              if (w_is_store) begin
                r_state  <= STORE;
                r_wr     <= 1'b1;
                ram_dout <= lsb_mem_data[7:0];
              end else begin
                r_state <= LOAD;
              end
            end else if (if_req && !flush) begin
              r_base  <= if_addr;
              r_cnt   <= 3'd0;
              r_buf   <= '0;
              ram_a   <= if_addr;
              r_state <= FETCH;
            end
          end
          STORE: begin
            // Stores are already committed, so a flush does not stop them.
            if (w_next_idx == w_len) begin
              r_wr       <= 1'b0;
              ram_a      <= '0;
              ram_dout   <= 8'd0;
              r_cnt      <= 3'd0;
              store_done <= 1'b1;
              r_state    <= IDLE;
            end else begin
              r_cnt    <= w_next_idx;
              ram_a    <= w_next_addr;
              ram_dout <= r_data[{w_next_idx[1:0], 3'b000} +: 8];
            end
          end
          default: begin
            if (flush) begin
              r_state <= IDLE;
              r_cnt   <= 3'd0;
              ram_a   <= '0;
            end else if (r_cnt == w_len) begin
              r_state <= IDLE;
              r_cnt   <= 3'd0;
              ram_a   <= '0;
              if (r_state == LOAD) begin
                mem_data_ready <= 1'b1;
                mem_data       <= w_ext;
                mem_id         <= r_id;
              end else begin
                if_data_ready <= 1'b1;
                if_data       <= w_word;
              end
            end else begin
              r_cnt <= w_next_idx;
              if (r_cnt != 3'd0) r_buf <= w_word;
              ram_a <= (w_next_idx < w_len) ? w_next_addr : '0;
            end
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_controller.sv
`default_nettype none
// Self-checking bench for memory_controller: byte RAM model, result scoreboard,
// access vector table and hand-timed corner-case sequences.
module tb_memory_controller;

  localparam logic [5:0] OP_LB  = 6'd1;
  localparam logic [5:0] OP_LH  = 6'd2;
  localparam logic [5:0] OP_LW  = 6'd3;
  localparam logic [5:0] OP_LBU = 6'd4;
  localparam logic [5:0] OP_LHU = 6'd5;
  localparam logic [5:0] OP_SB  = 6'd6;
  localparam logic [5:0] OP_SH  = 6'd7;
  localparam logic [5:0] OP_SW  = 6'd8;

  localparam int K_LOAD  = 0;
  localparam int K_STORE = 1;
  localparam int K_FETCH = 2;
  localparam int NVEC    = 17;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        flush = 1'b0;
  logic        lsb_mem_enable = 1'b0;
  logic [5:0]  lsb_mem_op = 6'd0;
  logic [31:0] lsb_mem_addr = 32'd0;
  logic [31:0] lsb_mem_data = 32'd0;
  logic [2:0]  lsb_mem_id = 3'd0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic [7:0]  ram_din = 8'd0;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic        mem_busy;
  logic        mem_data_ready;
  logic [31:0] mem_data;
  logic [2:0]  mem_id;
  logic        store_done;
  logic        if_data_ready;
  logic [31:0] if_data;

  memory_controller #(.XLEN(32), .ROB_W(3), .OP_W(6)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .lsb_mem_enable(lsb_mem_enable), .lsb_mem_op(lsb_mem_op),
    .lsb_mem_addr(lsb_mem_addr), .lsb_mem_data(lsb_mem_data), .lsb_mem_id(lsb_mem_id),
    .if_req(if_req), .if_addr(if_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .ram_a(ram_a), .ram_wr(ram_wr), .mem_busy(mem_busy),
    .mem_data_ready(mem_data_ready), .mem_data(mem_data), .mem_id(mem_id),
    .store_done(store_done), .if_data_ready(if_data_ready), .if_data(if_data)
  );

  always #5 clk = ~clk;

  // Byte RAM: read data appears one cycle after the address.
  logic [7:0]  ram [4096] = '{default: 8'h00};
  logic        pl_we = 1'b0;
  logic [11:0] pl_addr = 12'd0;
  logic [7:0]  pl_data = 8'd0;

  always @(posedge clk) begin
    if (pl_we) ram[pl_addr] <= pl_data;
    else if (ram_wr) ram[ram_a[11:0]] <= ram_dout;
    ram_din <= ram[ram_a[11:0]];
  end

  typedef struct {
    int          kind;
    logic [31:0] data;
    logic [2:0]  id;
  } exp_t;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  id;
    logic [31:0] exp;
  } vec_t;

  exp_t sb[$];
  vec_t vt [NVEC];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_ready = 0;
  int   n_fetch = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input int kind, input logic [31:0] data, input logic [2:0] id);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_pulse: got kind %0d data 0x%08h, expected no pulse", kind, data);
    end else begin
      e = sb.pop_front();
      check("sb_kind", 32'(kind), 32'(e.kind));
      if (kind != K_STORE) check("sb_data", data, e.data);
      if (kind == K_LOAD) check("sb_id", {29'd0, id}, {29'd0, e.id});
    end
  endtask

  always @(negedge clk) begin
    if (mem_data_ready) begin
      n_ready++;
      sb_pop(K_LOAD, mem_data, mem_id);
    end
    if (store_done) sb_pop(K_STORE, 32'd0, 3'd0);
    if (if_data_ready) begin
      n_fetch++;
      sb_pop(K_FETCH, if_data, 3'd0);
    end
  end

  function automatic bit is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    pl_addr = a;
    pl_data = d;
    pl_we   = 1'b1;
    @(posedge clk); #1;
    pl_we   = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(posedge clk); #1;
    while (mem_busy && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (mem_busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle: mem_busy got 1 after %0d cycles, expected 0", n);
    end
  endtask

  // Leaves lsb_mem_enable high; caller drops it after the next edge.
  task automatic lsb_issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] id);
    wait_idle();
    lsb_mem_op     = op;
    lsb_mem_addr   = a;
    lsb_mem_data   = d;
    lsb_mem_id     = id;
    lsb_mem_enable = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int first;
    int n0;

    vt[0]  = '{OP_LW,  32'h100, 32'h0,        3'd1, 32'h44332211};
    vt[1]  = '{OP_LB,  32'h200, 32'h0,        3'd2, 32'hFFFFFF80};
    vt[2]  = '{OP_LBU, 32'h200, 32'h0,        3'd3, 32'h00000080};
    vt[3]  = '{OP_LH,  32'h210, 32'h0,        3'd4, 32'hFFFF8001};
    vt[4]  = '{OP_LHU, 32'h210, 32'h0,        3'd5, 32'h00008001};
    vt[5]  = '{OP_LB,  32'h101, 32'h0,        3'd6, 32'h00000022};
    vt[6]  = '{OP_LW,  32'h101, 32'h0,        3'd7, 32'h00443322};
    vt[7]  = '{OP_SB,  32'h300, 32'h000000A5, 3'd0, 32'h0};
    vt[8]  = '{OP_LW,  32'h300, 32'h0,        3'd1, 32'h000000A5};
    vt[9]  = '{OP_SW,  32'h304, 32'hDEADBEEF, 3'd2, 32'h0};
    vt[10] = '{OP_LW,  32'h304, 32'h0,        3'd3, 32'hDEADBEEF};
    vt[11] = '{OP_LH,  32'h306, 32'h0,        3'd4, 32'hFFFFDEAD};
    vt[12] = '{OP_LHU, 32'h306, 32'h0,        3'd5, 32'h0000DEAD};
    vt[13] = '{OP_LW,  32'h030, 32'h0,        3'd6, 32'h00001234};
    vt[14] = '{OP_LW,  32'h400, 32'h0,        3'd7, 32'h01020304};
    vt[15] = '{OP_LW,  32'h500, 32'h0,        3'd0, 32'h55667788};
    vt[16] = '{OP_LBU, 32'h307, 32'h0,        3'd1, 32'h000000DE};

    rst = 1'b1;
    poke(12'h100, 8'h11); poke(12'h101, 8'h22); poke(12'h102, 8'h33); poke(12'h103, 8'h44);
    poke(12'h200, 8'h80); poke(12'h210, 8'h01); poke(12'h211, 8'h80); poke(12'h000, 8'h13);

    @(negedge clk);
    check("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    check("rst_ram_a", ram_a, 32'd0);
    check("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
    check("rst_ready", {31'd0, mem_data_ready}, 32'd0);
    check("rst_mem_data", mem_data, 32'd0);
    check("rst_store_done", {31'd0, store_done}, 32'd0);
    check("rst_if_ready", {31'd0, if_data_ready}, 32'd0);
    check("rst_busy", {31'd0, mem_busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // LW timing: address walk, latency and single pulse
    lsb_issue(OP_LW, 32'h100, 32'h0, 3'd5);
    sb.push_back('{K_LOAD, 32'h44332211, 3'd5});
    n0 = n_ready;
    first = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      lsb_mem_enable = 1'b0;
      @(negedge clk);
      if (k <= 4) check("lw_ram_a", ram_a, 32'h100 + 32'(k - 1));
      if (k == 2) check("lw_ram_wr", {31'd0, ram_wr}, 32'd0);
      if (k == 5) check("lw_ram_a_idle", ram_a, 32'd0);
      if (mem_data_ready && first == 0) first = k;
    end
    check("lw_latency", first, 6);
    check("lw_pulses", n_ready - n0, 1);
    drain();

    // SH byte sequencing
    lsb_issue(OP_SH, 32'h30, 32'hABCD1234, 3'd1);
    sb.push_back('{K_STORE, 32'h0, 3'd0});
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      lsb_mem_enable = 1'b0;
      @(negedge clk);
      check("sh_ram_wr", {31'd0, ram_wr}, {31'd0, (k <= 2)});
      check("sh_done", {31'd0, store_done}, {31'd0, (k == 3)});
      if (k == 1) begin
        check("sh_a0", ram_a, 32'h30);
        check("sh_d0", {24'd0, ram_dout}, 32'h34);
      end
      if (k == 2) begin
        check("sh_a1", ram_a, 32'h31);
        check("sh_d1", {24'd0, ram_dout}, 32'h12);
      end
    end
    drain();

    // store wins over a simultaneous fetch; fetch follows store_done
    lsb_issue(OP_SW, 32'h400, 32'h01020304, 3'd2);
    if_addr = 32'h0;
    if_req  = 1'b1;
    sb.push_back('{K_STORE, 32'h0, 3'd0});
    sb.push_back('{K_FETCH, 32'h00000013, 3'd0});
    @(negedge clk);
    check("coll_busy0", {31'd0, mem_busy}, 32'd1);
    first = 0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      lsb_mem_enable = 1'b0;
      @(negedge clk);
      if (k <= 4) check("coll_busy", {31'd0, mem_busy}, 32'd1);
      if (k == 5) check("coll_done", {31'd0, store_done}, 32'd1);
      if (k == 7) check("coll_fetch_a", ram_a, 32'h1);
      if (if_data_ready) begin
        first  = k;
        if_req = 1'b0;
      end
    end
    check("coll_fetch_lat", first, 11);
    drain();

    // if_req dropped mid-fetch still completes
    wait_idle();
    if_addr = 32'h100;
    if_req  = 1'b1;
    sb.push_back('{K_FETCH, 32'h44332211, 3'd0});
    n0 = n_fetch;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 2) if_req = 1'b0;
      @(negedge clk);
    end
    check("drop_fetch_pulses", n_fetch - n0, 1);
    drain();

    // flush during LOAD byte 2 aborts
    lsb_issue(OP_LW, 32'h100, 32'h0, 3'd3);
    n0 = n_ready;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      lsb_mem_enable = 1'b0;
      flush = (k == 3);
      @(negedge clk);
      if (k == 4) begin
        check("flush_ld_busy", {31'd0, mem_busy}, 32'd0);
        check("flush_ld_ram_a", ram_a, 32'd0);
      end
    end
    check("flush_ld_pulses", n_ready - n0, 0);

    // enable coincident with flush in IDLE is dropped
    wait_idle();
    lsb_mem_op = OP_LW; lsb_mem_addr = 32'h100; lsb_mem_id = 3'd4;
    lsb_mem_enable = 1'b1;
    flush = 1'b1;
    n0 = n_ready;
    @(posedge clk); #1;
    lsb_mem_enable = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("flush_idle_busy", {31'd0, mem_busy}, 32'd0);
    check("flush_idle_ram_a", ram_a, 32'd0);
    repeat (7) @(negedge clk);
    check("flush_idle_pulses", n_ready - n0, 0);

    // flush during SW: store still completes
    lsb_issue(OP_SW, 32'h500, 32'h55667788, 3'd2);
    sb.push_back('{K_STORE, 32'h0, 3'd0});
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      lsb_mem_enable = 1'b0;
      flush = (k == 2);
      @(negedge clk);
      if (k <= 4) begin
        check("flush_sw_wr", {31'd0, ram_wr}, 32'd1);
        check("flush_sw_a", ram_a, 32'h500 + 32'(k - 1));
      end
      if (k == 5) check("flush_sw_done", {31'd0, store_done}, 32'd1);
    end
    drain();

    // reset mid-fetch
    wait_idle();
    if_addr = 32'h100;
    if_req  = 1'b1;
    n0 = n_fetch;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    if_req = 1'b0;
    @(negedge clk);
    check("rst_mid_pre_a", ram_a, 32'h101);
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_ram_a", ram_a, 32'd0);
    check("rst_mid_ram_wr", {31'd0, ram_wr}, 32'd0);
    check("rst_mid_busy", {31'd0, mem_busy}, 32'd0);
    check("rst_mid_if_ready", {31'd0, if_data_ready}, 32'd0);
    check("rst_mid_if_data", if_data, 32'd0);
    check("rst_mid_mem_data", mem_data, 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_mid_fetch_pulses", n_fetch - n0, 0);

    // rdy low for 3 cycles mid-LW delays result by 3 cycles
    lsb_issue(OP_LW, 32'h100, 32'h0, 3'd6);
    sb.push_back('{K_LOAD, 32'h44332211, 3'd6});
    first = 0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      lsb_mem_enable = 1'b0;
      rdy = !(k >= 2 && k <= 4);
      @(negedge clk);
      if (k == 3) check("stall_ram_a", ram_a, 32'h101);
      if (mem_data_ready && first == 0) first = k;
    end
    rdy = 1'b1;
    check("stall_latency", first, 9);
    drain();

    // access vector table
    for (int i = 0; i < NVEC; i++) begin
      lsb_issue(vt[i].op, vt[i].addr, vt[i].wdata, vt[i].id);
      if (is_store(vt[i].op)) sb.push_back('{K_STORE, 32'h0, 3'd0});
      else sb.push_back('{K_LOAD, vt[i].exp, vt[i].id});
      @(posedge clk); #1;
      lsb_mem_enable = 1'b0;
    end
    drain();

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
